// File: rtl/int_sequencer.sv
// Interrupt entry/exit sequencer: flush, save SRR0/SRR1, mask MSR, vector the PC,
// and the single-cycle rfi restore of PC/MSR from SRR0/SRR1.
//
// state  | meaning
// IDLE   | waiting for a valid decision-stage interrupt op or rfi
// FLUSH  | kill younger pipeline stages
// SAVE   | write SRR0/SRR1 and the masked MSR
// VECTOR | redirect PC to the vector, clear a pending external request
// RFI    | restore PC from SRR0 and MSR from SRR1
module int_sequencer #(
  parameter int PC_W    = 32,
  parameter int MSR_W   = 32,
  parameter int INTOP_W = 2,
  parameter int EE_BIT  = 16,
  parameter int PR_BIT  = 17
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INTOP_W-1:0] intOp,
  input  logic               instr_valid,
  input  logic               rfi,
  input  logic [PC_W-1:0]    cur_pc,
  input  logic [PC_W-1:0]    next_pc,
  input  logic [0:MSR_W-1]   msr_in,
  input  logic [PC_W-1:0]    srr0_in,
  input  logic [0:MSR_W-1]   srr1_in,
  input  logic [PC_W-1:0]    intAddr,
  output logic [INTOP_W-1:0] int_op_q,
  output logic               busy,
  output logic               flush,
  output logic               srr0_wr,
  output logic [PC_W-1:0]    srr0_out,
  output logic               srr1_wr,
  output logic [0:MSR_W-1]   srr1_out,
  output logic               msr_wr,
  output logic [0:MSR_W-1]   msr_out,
  output logic               pc_wr,
  output logic [PC_W-1:0]    pc_out,
  output logic               int_clr
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FLUSH  = 3'd1,
    S_SAVE   = 3'd2,
    S_VECTOR = 3'd3,
    S_RFI    = 3'd4
  } state_t;

  localparam logic [INTOP_W-1:0] OP_NONE = INTOP_W'(0);
  localparam logic [INTOP_W-1:0] OP_EXT  = INTOP_W'(1);
  localparam logic [INTOP_W-1:0] OP_TRAP = INTOP_W'(3);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [INTOP_W-1:0]   r_int_op;
  logic [PC_W-1:0]      r_ret;
  logic [0:MSR_W-1]     r_msr;
  logic [0:MSR_W-1]     w_msr_masked;
  logic                 w_accept_int;

  assign w_accept_int = (r_state == S_IDLE) && instr_valid && (intOp != OP_NONE);
  assign int_op_q     = r_int_op;

  // TRAP re-executes the faulting instruction; SC and EXT resume after it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_int_op <= '0;
      r_ret    <= '0;
      r_msr    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept_int) begin
        r_int_op <= intOp;
        r_msr    <= msr_in;
        r_ret    <= (intOp == OP_TRAP) ? cur_pc : next_pc;
      end
    end
  end

  always_comb begin
    w_msr_masked         = r_msr;
    w_msr_masked[EE_BIT] = 1'b0;
    w_msr_masked[PR_BIT] = 1'b0;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    flush       = 1'b0;
    srr0_wr     = 1'b0;
    srr0_out    = '0;
    srr1_wr     = 1'b0;
    srr1_out    = '0;
    msr_wr      = 1'b0;
    msr_out     = '0;
    pc_wr       = 1'b0;
    pc_out      = '0;
    int_clr     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept_int) begin
          w_state_nxt = S_FLUSH;
        end else if (instr_valid && rfi) begin
          w_state_nxt = S_RFI;
        end
      end
      S_FLUSH: begin
        busy        = 1'b1;
        flush       = 1'b1;
        w_state_nxt = S_SAVE;
      end
      S_SAVE: begin
        busy        = 1'b1;
        srr0_wr     = 1'b1;
        srr0_out    = r_ret;
        srr1_wr     = 1'b1;
        srr1_out    = r_msr;
        msr_wr      = 1'b1;
        msr_out     = w_msr_masked;
        w_state_nxt = S_VECTOR;
      end
      S_VECTOR: begin
        busy        = 1'b1;
        flush       = 1'b1;
        pc_wr       = 1'b1;
        pc_out      = intAddr;
        int_clr     = (r_int_op == OP_EXT);
        w_state_nxt = S_IDLE;
      end
      S_RFI: begin
        flush       = 1'b1;
        pc_wr       = 1'b1;
        pc_out      = srr0_in;
        msr_wr      = 1'b1;
        msr_out     = srr1_in;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
